pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//   8-bit program counter with a small hardware return stack, built on clocked-with-clear
//   storage like our D flip-flop primitives. Sits directly downstream of that flip-flop stage.
//   Supplies the instruction-fetch address each cycle.
//   Supports sequential step, absolute jump, call (push return address) and return (pop).
// PARAMETERS
//   WIDTH      8    width of PC, target and stack entries
//   DEPTH      4    number of return-stack entries (>=1)
//   RESET_VEC  0    PC value loaded on reset (WIDTH bits)
// PORTS
//   clock        in   1      rising-edge clock
//   clear_n      in   1      asynchronous active-low reset
//   enable       in   1      advance this cycle; 0 = hold everything
//   jump         in   1      load PC from target
//   call         in   1      push PC+1, load PC from target
//   ret          in   1      pop stack top into PC
//   target       in   WIDTH  jump/call destination
//   pc           out  WIDTH  current fetch address (registered)
//   stack_empty  out  1      1 when stack holds 0 entries
//   stack_full   out  1      1 when stack holds DEPTH entries
//   stack_err    out  1      sticky: illegal push/pop attempted
// BEHAVIOUR
//   Reset (clear_n=0, asynchronous, no clock needed):
//   - pc=RESET_VEC, stack_empty=1, stack_full=0, stack_err=0.
//   - Stack pointer sp=0; entry contents are don't-care.
//   - Release is sampled on the next rising edge.
//   All updates occur on the rising edge of clock. Outputs reflect the new state one edge
//   after the request (1-cycle latency); there is no combinational path from input to output.
//   When enable=0, pc, sp, stack contents and stack_err all hold, regardless of other inputs.
//   When enable=1, exactly one operation applies, chosen by fixed priority
//   ret > call > jump > step:
//   - ret,  sp>0:     pc <= stack[sp-1]; sp <= sp-1.
//   - ret,  sp==0:    pc holds; sp holds; stack_err <= 1.
//   - call, sp<DEPTH: stack[sp] <= pc+1 (mod 2^WIDTH); sp <= sp+1; pc <= target.
//   - call, sp==DEPTH: pc holds (no jump); nothing pushed; stack_err <= 1.
//   - jump:           pc <= target; stack untouched.
//   - none asserted:  pc <= pc+1.
//   Arithmetic: all PC arithmetic is modulo 2^WIDTH, so 0xFF+1 wraps to 0x00 with no flag;
//   a pushed return address wraps the same way.
//   Flags: stack_empty = (sp==0); stack_full = (sp==DEPTH). Both are decoded from the
//   registered sp, so they change in the same cycle as sp.
//   stack_err stays at 1 until clear_n is asserted; no other input clears it.
//   Lower-priority requests asserted together with a higher one are ignored entirely
//   (e.g. ret+jump: the jump target is unused).
//   Reset mid-operation: clear_n overrides any in-flight request immediately, and the
//   stack is emptied.
// TESTING
//   1. Reset to RESET_VEC=0x10, enable=1, no requests for 3 edges
//      -> pc 0x11, 0x12, 0x13; stack_empty=1.
//   2. pc=0xFE, step twice -> pc 0xFF then 0x00; stack_err=0.
//   3. pc=0x20, call target=0x80 -> pc=0x80, stack_empty=0.
//      Then step; then ret -> pc=0x81 then 0x21; stack_empty=1.
//   4. Four calls (DEPTH=4) -> stack_full=1. A fifth call target=0x55 -> pc unchanged,
//      stack_err=1. Then four rets -> the return addresses come back in LIFO order.
//   5. ret with stack empty -> pc holds, stack_err=1, and it stays 1 across later steps.
//      Then clear_n=0 mid-cycle -> pc=RESET_VEC and stack_err=0 at once, without a clock edge.
//   6. ret+call+jump together with 1 entry on the stack -> only ret applies.
//      Then enable=0 with jump=1 -> pc holds.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with a small LIFO return stack: step, jump, call (push PC+1) and return (pop).
// All state is registered; the status flags are registered alongside the stack pointer.
module pc_stack_unit #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int             SPW     = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic             err_q, err_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] next_pc_s;

  // Select the current top-of-stack entry (slot sp-1) without an out-of-range index.
  always_comb begin
    top_s = stack_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      top_s = (int'(sp_q) == i + 1) ? stack_q[i] : top_s;
    end
  end

  // Next-state logic: one operation per enabled cycle, priority ret > call > jump > step.
  always_comb begin
    next_pc_s = pc_q + PC_ONE;
    pc_d      = pc_q;
    sp_d      = sp_q;
    err_d     = err_q;
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end

    if (enable) begin
      if (ret) begin
        if (sp_q != SP_ZERO) begin
          pc_d = top_s;
          sp_d = sp_q - SP_ONE;
        end else begin
          err_d = 1'b1;
        end
      end else if (call) begin
        if (sp_q != SP_FULL) begin
          for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = (int'(sp_q) == i) ? next_pc_s : stack_q[i];
          end
          sp_d = sp_q + SP_ONE;
          pc_d = target;
        end else begin
          err_d = 1'b1;
        end
      end else if (jump) begin
        pc_d = target;
      end else begin
        pc_d = next_pc_s;
      end
    end else begin
      pc_d = pc_q;
    end

    empty_d = (sp_d == SP_ZERO);
    full_d  = (sp_d == SP_FULL);
  end

  // State registers; clear_n empties the stack and drops the sticky error immediately.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc_q    <= RESET_VEC;
      sp_q    <= SP_ZERO;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign pc          = pc_q;
  assign stack_empty = empty_q;
  assign stack_full  = full_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed testbench for pc_stack_unit (WIDTH=8, DEPTH=4, RESET_VEC=0x10).
module tb_pc_stack_unit;

  logic       clock;
  logic       clear_n;
  logic       enable;
  logic       jump;
  logic       call;
  logic       ret;
  logic [7:0] target;
  logic [7:0] pc;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack_unit #(
    .WIDTH(8),
    .DEPTH(4),
    .RESET_VEC(8'h10)
  ) dut (
    .clock(clock),
    .clear_n(clear_n),
    .enable(enable),
    .jump(jump),
    .call(call),
    .ret(ret),
    .target(target),
    .pc(pc),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .stack_err(stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic r, input logic c, input logic j, input logic [7:0] t);
    ret    = r;
    call   = c;
    jump   = j;
    target = t;
  endtask

  logic [7:0] exp_ret [4];

  initial begin
    clear_n = 1'b0;
    enable  = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    chk_eq("rst_pc",    32'(pc),          32'h10);
    chk_eq("rst_empty", 32'(stack_empty), 32'h1);
    chk_eq("rst_full",  32'(stack_full),  32'h0);
    chk_eq("rst_err",   32'(stack_err),   32'h0);

    // 1: stepping from the reset vector
    clear_n = 1'b1;
    enable  = 1'b1;
    tick(); chk_eq("step1", 32'(pc), 32'h11);
    tick(); chk_eq("step2", 32'(pc), 32'h12);
    tick(); chk_eq("step3", 32'(pc), 32'h13);
    chk_eq("step_empty", 32'(stack_empty), 32'h1);

    // 2: wraparound
    set_req(1'b0, 1'b0, 1'b1, 8'hFE);
    tick(); chk_eq("jump_fe", 32'(pc), 32'hFE);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    tick(); chk_eq("wrap_ff", 32'(pc), 32'hFF);
    tick(); chk_eq("wrap_00", 32'(pc), 32'h00);
    chk_eq("wrap_err", 32'(stack_err), 32'h0);

    // 3: call / step / ret
    set_req(1'b0, 1'b0, 1'b1, 8'h20);
    tick(); chk_eq("jump_20", 32'(pc), 32'h20);
    set_req(1'b0, 1'b1, 1'b0, 8'h80);
    tick(); chk_eq("call_pc", 32'(pc), 32'h80);
    chk_eq("call_empty", 32'(stack_empty), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    tick(); chk_eq("sub_step", 32'(pc), 32'h81);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); chk_eq("ret_pc", 32'(pc), 32'h21);
    chk_eq("ret_empty", 32'(stack_empty), 32'h1);

    // 4: fill the stack, overflow, then unwind in LIFO order
    exp_ret[0] = 8'h22; exp_ret[1] = 8'h31; exp_ret[2] = 8'h41; exp_ret[3] = 8'h51;
    for (int i = 0; i < 4; i++) begin
      chk_eq("pre_full", 32'(stack_full), 32'h0);
      set_req(1'b0, 1'b1, 1'b0, 8'(8'h30 + 8'(i) * 8'h10));
      tick();
      chk_eq("deep_call_pc", 32'(pc), 32'(8'h30 + 8'(i) * 8'h10));
    end
    chk_eq("full", 32'(stack_full), 32'h1);
    chk_eq("full_err0", 32'(stack_err), 32'h0);
    set_req(1'b0, 1'b1, 1'b0, 8'h55);
    tick();
    chk_eq("ovf_pc",   32'(pc),         32'h60);
    chk_eq("ovf_err",  32'(stack_err),  32'h1);
    chk_eq("ovf_full", 32'(stack_full), 32'h1);
    for (int i = 3; i >= 0; i--) begin
      set_req(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk_eq("lifo_pc", 32'(pc), 32'(exp_ret[i]));
      chk_eq("lifo_full", 32'(stack_full), 32'h0);
    end
    chk_eq("unwind_empty", 32'(stack_empty), 32'h1);
    chk_eq("unwind_err",   32'(stack_err),   32'h1);

    // 5: underflow is sticky until clear_n, which acts without a clock edge
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    clear_n = 1'b0;
    #1;
    chk_eq("rst2_err", 32'(stack_err), 32'h0);
    chk_eq("rst2_pc",  32'(pc),        32'h10);
    tick();
    clear_n = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk_eq("unf_pc",  32'(pc),        32'h10);
    chk_eq("unf_err", 32'(stack_err), 32'h1);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    tick(); chk_eq("sticky_pc1", 32'(pc), 32'h11);
    chk_eq("sticky_err1", 32'(stack_err), 32'h1);
    tick(); chk_eq("sticky_pc2", 32'(pc), 32'h12);
    chk_eq("sticky_err2", 32'(stack_err), 32'h1);
    #2;
    clear_n = 1'b0;
    #1;
    chk_eq("async_pc",    32'(pc),          32'h10);
    chk_eq("async_err",   32'(stack_err),   32'h0);
    chk_eq("async_empty", 32'(stack_empty), 32'h1);

    // 6: priority and hold
    tick();
    clear_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 8'h70);
    tick(); chk_eq("p_call", 32'(pc), 32'h70);
    set_req(1'b1, 1'b1, 1'b1, 8'h99);
    tick();
    chk_eq("prio_pc",    32'(pc),          32'h11);
    chk_eq("prio_empty", 32'(stack_empty), 32'h1);
    chk_eq("prio_err",   32'(stack_err),   32'h0);
    enable = 1'b0;
    set_req(1'b0, 1'b0, 1'b1, 8'hAA);
    tick(); chk_eq("hold_jump", 32'(pc), 32'h11);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); chk_eq("hold_ret_pc", 32'(pc), 32'h11);
    chk_eq("hold_ret_err", 32'(stack_err), 32'h0);
    set_req(1'b0, 1'b1, 1'b0, 8'hCC);
    tick(); chk_eq("hold_call_pc", 32'(pc), 32'h11);
    chk_eq("hold_call_empty", 32'(stack_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
